// File: rtl/atom_mem_arbiter.sv
// Arbitrates the single spram port between CPU accesses and the ioctl utility-ROM
// download, buffering download bytes in a small FIFO with registered back-pressure.
module atom_mem_arbiter #(
  parameter logic [17:0] DL_BASE    = 18'h17000,
  parameter int unsigned DL_SIZE    = 4096,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [17:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_rom,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        dl_overflow,
  output logic        dl_done,
  output logic [17:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CPU_ADDR = 2'd1;
  localparam logic [1:0] CPU_DATA = 2'd2;
  localparam logic [1:0] DL_WRITE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          ready_q;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [17:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic [19:0]   fifo_q [FIFO_DEPTH];
  logic [19:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dl_wait_q, dl_wait_d;
  logic          dl_overflow_q, dl_overflow_d;
  logic          dl_done_q, dl_done_d;
  logic          dl_active_q;
  logic          done_pend_q, done_pend_d;

  logic          dl_rise, dl_fall, push, pop, pend;
  logic          fifo_hi, fifo_full, fifo_empty, in_window;
  logic [19:0]   head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dl_rise    = dl_active & ~dl_active_q;
  assign dl_fall    = ~dl_active & dl_active_q;
  assign in_window  = dl_addr < 25'(DL_SIZE);
  // "Full" for arbitration is the dl_wait threshold: an honoured dl_wait never lets
  // the count reach FIFO_DEPTH, so only this level can starve a held cpu_req.
  assign fifo_hi    = count_q >= CW'(FIFO_DEPTH - 1);
  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign head       = fifo_q[rd_ptr_q];
  assign push       = dl_wr & dl_active & in_window & (~fifo_full | dl_rise);

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cpu_dout_d = cpu_dout_q;
    cpu_ack_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: if (ready_q) begin
        // The ack cycle never re-samples cpu_req; a held request waits one edge.
        if (cpu_req && !cpu_ack_q && !fifo_hi) begin
          state_d    = CPU_ADDR;
          is_wr_d    = cpu_we;
          mem_addr_d = cpu_addr;
          if (cpu_we) begin
            mem_din_d = cpu_din;
            mem_we_d  = ~cpu_rom;
          end
        end else if (!fifo_empty && !dl_rise) begin
          state_d    = DL_WRITE;
          pop        = 1'b1;
          mem_addr_d = DL_BASE + {6'd0, head[19:8]};
          mem_din_d  = head[7:0];
          mem_we_d   = 1'b1;
        end
      end
      CPU_ADDR: begin
        if (is_wr_q) begin
          state_d   = IDLE;
          cpu_ack_d = 1'b1;
        end else begin
          state_d = CPU_DATA;
        end
      end
      CPU_DATA: begin
        state_d    = IDLE;
        cpu_ack_d  = 1'b1;
        cpu_dout_d = mem_dout;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = dl_rise ? '0 : wr_ptr_q;
    rd_ptr_d = dl_rise ? '0 : rd_ptr_q;
    count_d  = dl_rise ? '0 : count_q;
    if (push) begin
      fifo_d[wr_ptr_d] = {dl_addr[11:0], dl_data};
      wr_ptr_d         = ptr_inc(wr_ptr_d);
      count_d          = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d  = count_d - CW'(1);
    end
    dl_wait_d     = count_d >= CW'(FIFO_DEPTH - 1);
    dl_overflow_d = dl_rise ? 1'b0 : dl_overflow_q;
    if (dl_wr && dl_active && !push) dl_overflow_d = 1'b1;
    pend          = done_pend_q | dl_fall;
    dl_done_d     = pend & ~dl_active & fifo_empty & (state_q == IDLE);
    done_pend_d   = pend & ~dl_done_d & ~dl_rise;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      is_wr_q       <= 1'b0;
      cpu_dout_q    <= '0;
      cpu_ack_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dl_wait_q     <= 1'b0;
      dl_overflow_q <= 1'b0;
      dl_done_q     <= 1'b0;
      dl_active_q   <= 1'b0;
      done_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= 1'b1;
      is_wr_q       <= is_wr_d;
      cpu_dout_q    <= cpu_dout_d;
      cpu_ack_q     <= cpu_ack_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dl_wait_q     <= dl_wait_d;
      dl_overflow_q <= dl_overflow_d;
      dl_done_q     <= dl_done_d;
      dl_active_q   <= dl_active;
      done_pend_q   <= done_pend_d;
    end
  end

  assign cpu_dout    = cpu_dout_q;
  assign cpu_ack     = cpu_ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign dl_wait     = dl_wait_q;
  assign dl_overflow = dl_overflow_q;
  assign dl_done     = dl_done_q;

endmodule

// File: tb/tb_atom_mem_arbiter.sv
// Self-checking bench for atom_mem_arbiter: CPU access table, download stream,
// window overflow, arbitration priority and reset-abort sequences.
module tb_atom_mem_arbiter;

  localparam logic [17:0] DLB = 18'h17000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_rom;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        dl_active, dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait, dl_overflow, dl_done;
  logic [17:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we;

  logic        pre_we;
  logic [17:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  spram [0:262143];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int prio_pushed;
  logic [25:0] wq [$];
  logic [7:0]  rq [$];

  typedef struct {
    logic        we;
    logic        rom;
    logic [17:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    int unsigned exp_lat;
    int unsigned exp_wes;
  } vec_t;
  vec_t vecs [10];

  atom_mem_arbiter #(.DL_BASE(18'h17000), .DL_SIZE(4096), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_rom(cpu_rom), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait), .dl_overflow(dl_overflow), .dl_done(dl_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous spram model: read data one edge after the address edge.
  always @(posedge clk) begin
    if (pre_we) spram[pre_addr] <= pre_data;
    else if (mem_we) spram[mem_addr] <= mem_din;
    mem_dout <= spram[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Every wait goes through here so spram writes are checked against the queue.
  task automatic tick();
    logic [25:0] e;
    @(negedge clk);
    if (mem_we) begin
      if (wq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected mem write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_din);
      end else begin
        e = wq.pop_front();
        chk("mem write", {38'd0, mem_addr, mem_din}, {38'd0, e});
      end
    end
    if (dl_done) done_cnt++;
  endtask

  function automatic logic [63:0] outs();
    return {25'd0, cpu_dout, cpu_ack, mem_addr, mem_din, mem_we, dl_wait, dl_overflow, dl_done};
  endfunction

  task automatic cpu_txn(input string nm, input vec_t v);
    int unsigned n, wes;
    bit got;
    cpu_req = 1'b1; cpu_we = v.we; cpu_rom = v.rom; cpu_addr = v.addr; cpu_din = v.din;
    if (v.we && !v.rom) wq.push_back({v.addr, v.din});
    if (!v.we) rq.push_back(v.exp_dout);
    n = 0; wes = 0; got = 0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        chk({nm, " addr"}, 64'(mem_addr), 64'(v.addr));
        chk({nm, " we"}, 64'(mem_we), 64'(v.we & ~v.rom));
      end
      if (mem_we && mem_addr == v.addr) wes++;
      if (cpu_ack) got = 1;
    end
    cpu_req = 1'b0;
    if (got) chk({nm, " ack latency"}, 64'(n), 64'(v.exp_lat));
    else chk({nm, " ack seen"}, 64'(got), 64'd1);
    chk({nm, " mem_we cycles"}, 64'(wes), 64'(v.exp_wes));
    if (!v.we) chk({nm, " dout"}, 64'(cpu_dout), 64'(rq.pop_front()));
    tick();
    chk({nm, " single ack"}, 64'(cpu_ack), 64'd0);
  endtask

  task automatic prod_step();
    logic [7:0] d;
    if (prio_pushed < 4 && !dl_wait) begin
      d = 8'hC0 + 8'(prio_pushed);
      dl_wr = 1'b1; dl_addr = 25'(32 + prio_pushed); dl_data = d;
      wq.push_back({DLB + 18'(32 + prio_pushed), d});
      prio_pushed++;
    end else begin
      dl_wr = 1'b0;
    end
  endtask

  function automatic vec_t rd(input logic [17:0] a, input logic [7:0] e);
    return '{we: 1'b0, rom: 1'b0, addr: a, din: 8'h00, exp_dout: e, exp_lat: 3, exp_wes: 0};
  endfunction

  function automatic vec_t wr(input logic [17:0] a, input logic [7:0] d, input logic r);
    return '{we: 1'b1, rom: r, addr: a, din: d, exp_dout: 8'h00, exp_lat: 2, exp_wes: (r ? 0 : 1)};
  endfunction

  initial begin
    int unsigned n, acks, dlw, base, off;
    vecs[0] = rd(18'h0C000, 8'hA5);
    vecs[1] = wr(18'h00100, 8'h3C, 1'b0);
    vecs[2] = rd(18'h00100, 8'h3C);
    vecs[3] = wr(18'h00100, 8'h5A, 1'b1);
    vecs[4] = rd(18'h00100, 8'h3C);
    vecs[5] = wr(18'h3FFFF, 8'h77, 1'b0);
    vecs[6] = rd(18'h3FFFF, 8'h77);
    vecs[7] = wr(18'h00101, 8'hC3, 1'b0);
    vecs[8] = rd(18'h00101, 8'hC3);
    vecs[9] = rd(18'h00100, 8'h3C);

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_rom = 1'b0; cpu_addr = '0; cpu_din = '0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    tick();
    pre_we = 1'b1; pre_addr = 18'h0C000; pre_data = 8'hA5;
    tick();
    pre_we = 1'b0;
    chk("reset outputs", outs(), 64'd0);

    // Request already pending at reset release: no grant on the first edge.
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
    tick();
    chk("no grant at first edge", 64'(mem_addr), 64'd0);
    n = 0;
    while (!cpu_ack && n < 10) begin tick(); n++; end
    chk("post-reset ack", 64'(cpu_ack), 64'd1);
    chk("post-reset data", 64'(cpu_dout), 64'hA5);
    cpu_req = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) cpu_txn($sformatf("vec%0d", i), vecs[i]);

    // Held cpu_req: ack cycle is skipped, second grant on the following edge.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
    n = 0; acks = 0;
    while (acks < 2 && n < 30) begin
      tick(); n++;
      if (cpu_ack) acks++;
    end
    cpu_req = 1'b0;
    chk("held req second ack cycle", 64'(n), 64'd7);
    tick();

    // Window boundary and overflow.
    dl_active = 1'b1;
    repeat (3) tick();
    dl_wr = 1'b1; dl_addr = 25'd4095; dl_data = 8'hEE;
    wq.push_back({18'h17FFF, 8'hEE});
    tick();
    dl_addr = 25'd4096; dl_data = 8'h11;
    tick();
    dl_wr = 1'b0;
    repeat (6) tick();
    chk("overflow set", 64'(dl_overflow), 64'd1);
    chk("in-window byte drained", 64'(wq.size()), 64'd0);
    base = done_cnt;
    dl_active = 1'b0;
    repeat (6) tick();
    chk("done after overflow run", 64'(done_cnt - base), 64'd1);
    dl_active = 1'b1;
    tick(); tick();
    chk("overflow cleared on rise", 64'(dl_overflow), 64'd0);

    // FIFO at 3 entries beats a waiting CPU read.
    prio_pushed = 0; dlw = 0; acks = 0; n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
    prod_step();
    while (acks < 2 && n < 60) begin
      tick(); n++;
      if (mem_we && mem_addr >= DLB) dlw++;
      if (cpu_ack) begin
        acks++;
        chk("prio read data", 64'(cpu_dout), 64'hA5);
        if (acks == 2) begin
          chk("prio dl writes before 2nd ack", 64'(dlw), 64'd2);
          cpu_req = 1'b0;
        end
      end
      prod_step();
    end
    dl_wr = 1'b0;
    chk("prio two acks", 64'(acks), 64'd2);
    n = 0;
    while (wq.size() != 0 && n < 50) begin tick(); n++; end
    chk("prio bytes drained", 64'(wq.size()), 64'd0);

    // Full download with a permanently busy CPU.
    dl_active = 1'b0;
    repeat (3) tick();
    dl_active = 1'b1;
    tick(); tick();
    base = done_cnt;
    off = 0; n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
    while ((off < 4096 || cpu_req) && n < 60000) begin
      tick(); n++;
      if (cpu_ack) begin
        chk("dl cpu read", 64'(cpu_dout), 64'hA5);
        if (off >= 4096) cpu_req = 1'b0;
      end
      if (off < 4096 && !dl_wait) begin
        dl_wr = 1'b1; dl_addr = 25'(off); dl_data = 8'(off);
        wq.push_back({DLB + 18'(off), 8'(off)});
        off++;
      end else begin
        dl_wr = 1'b0;
      end
    end
    dl_wr = 1'b0;
    chk("dl feed complete", 64'(off), 64'd4096);
    n = 0;
    while (wq.size() != 0 && n < 200) begin tick(); n++; end
    chk("dl no byte lost", 64'(wq.size()), 64'd0);
    dl_active = 1'b0;
    repeat (20) tick();
    chk("dl single done", 64'(done_cnt - base), 64'd1);
    chk("dl no overflow", 64'(dl_overflow), 64'd0);
    cpu_txn("dl last byte", rd(18'h17FFF, 8'hFF));
    cpu_txn("dl first byte", rd(18'h17000, 8'h00));
    cpu_txn("dl mid byte", rd(18'h17ABC, 8'hBC));

    // Reset during CPU_ADDR aborts the read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h0C000;
    tick();
    chk("abort addr presented", 64'(mem_addr), 64'h0C000);
    reset = 1'b1;
    #1;
    chk("async reset outputs", outs(), 64'd0);
    acks = 0;
    repeat (3) begin tick(); if (cpu_ack) acks++; end
    reset = 1'b0; cpu_req = 1'b0;
    repeat (4) begin tick(); if (cpu_ack) acks++; end
    chk("no ack after abort", 64'(acks), 64'd0);
    cpu_txn("clean read after abort", rd(18'h0C000, 8'hA5));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
